// File: rtl/tick_irq_if.sv
// CPU I/O bus bundle for the tick/interrupt timer: write/read strobes,
// address, write data and combinational read data.
interface tick_irq_if;
  logic        io_wr;
  logic        io_rd;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;

  modport master (
    output io_wr,
    output io_rd,
    output io_addr,
    output io_dout,
    input  io_din
  );

  modport slave (
    input  io_wr,
    input  io_rd,
    input  io_addr,
    input  io_dout,
    output io_din
  );
endinterface

// File: rtl/tick_irq.sv
// Free-running 16-bit tick counter with reload, pending/lost tracking and a
// two-state interrupt requester that defers delivery while a fetch completes.
module tick_irq #(
  parameter logic [15:0] BASE = 16'h2000
) (
  input  logic        clk,
  input  logic        resetq,
  tick_irq_if.slave   io,
  input  logic        fetch_pending,
  output logic        interrupt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ticks_q, ticks_d;
  logic [15:0] reload_q, reload_d;
  logic        run_q, run_d;
  logic        ie_q, ie_d;
  logic        pend_q, pend_d;
  logic [3:0]  lost_q, lost_d;

  logic        wr_ticks_s;
  logic        wr_reload_s;
  logic        wr_ctrl_s;
  logic        wr_lost_s;
  logic        overflow_s;
  logic        deliver_s;
  logic        unused_rd_s;

  // Reads are side-effect free, so the read strobe carries no information here.
  assign unused_rd_s = io.io_rd;

  assign wr_ticks_s  = io.io_wr && (io.io_addr == BASE);
  assign wr_reload_s = io.io_wr && (io.io_addr == (BASE + 16'd1));
  assign wr_ctrl_s   = io.io_wr && (io.io_addr == (BASE + 16'd2));
  assign wr_lost_s   = io.io_wr && (io.io_addr == (BASE + 16'd3));

  // A software TICKS write in the wrap cycle swallows the overflow event.
  assign overflow_s  = run_q && (ticks_q == 16'hFFFF) && !wr_ticks_s;
  assign deliver_s   = interrupt;

  // Interrupt line: only in REQ and only when no fetch is in flight.
  always_comb begin
    interrupt = 1'b0;
    if (state_q == ST_REQ) begin
      interrupt = !fetch_pending;
    end else begin
      interrupt = 1'b0;
    end
  end

  // Register-map next-state: counter, reload, control bits and lost counter.
  always_comb begin
    ticks_d  = ticks_q;
    reload_d = reload_q;
    run_d    = run_q;
    ie_d     = ie_q;
    pend_d   = pend_q;
    lost_d   = lost_q;

    if (wr_ticks_s) begin
      ticks_d = io.io_dout;
    end else if (overflow_s) begin
      ticks_d = reload_q;
    end else if (run_q) begin
      ticks_d = ticks_q + 16'd1;
    end else begin
      ticks_d = ticks_q;
    end

    if (wr_reload_s) begin
      reload_d = io.io_dout;
    end else begin
      reload_d = reload_q;
    end

    if (wr_ctrl_s) begin
      run_d = io.io_dout[0];
    end else begin
      run_d = run_q;
    end

    if (deliver_s) begin
      ie_d = 1'b0;
    end else if (wr_ctrl_s) begin
      ie_d = io.io_dout[1];
    end else begin
      ie_d = ie_q;
    end

    // A fresh event outranks both delivery and a software clear.
    if (overflow_s) begin
      pend_d = 1'b1;
    end else if (deliver_s) begin
      pend_d = 1'b0;
    end else if (wr_ctrl_s && io.io_dout[2]) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    if (wr_lost_s) begin
      lost_d = 4'd0;
    end else if (overflow_s && pend_q && (lost_q != 4'hF)) begin
      lost_d = lost_q + 4'd1;
    end else begin
      lost_d = lost_q;
    end
  end

  // Interrupt FSM; leaving REQ looks at next-cycle IE/PEND so a disable never
  // leaves a stale request able to fire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_q && ie_q) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (deliver_s || !ie_d || !pend_d) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q  <= ST_IDLE;
      ticks_q  <= 16'd0;
      reload_q <= 16'd0;
      run_q    <= 1'b0;
      ie_q     <= 1'b0;
      pend_q   <= 1'b0;
      lost_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      ticks_q  <= ticks_d;
      reload_q <= reload_d;
      run_q    <= run_d;
      ie_q     <= ie_d;
      pend_q   <= pend_d;
      lost_q   <= lost_d;
    end
  end

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    io.io_din = 16'd0;
    case (io.io_addr)
      BASE:          io.io_din = ticks_q;
      BASE + 16'd1:  io.io_din = reload_q;
      BASE + 16'd2:  io.io_din = {13'd0, pend_q, ie_q, run_q};
      BASE + 16'd3:  io.io_din = {12'd0, lost_q};
      default:       io.io_din = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_tick_irq.sv
// Self-checking bench for tick_irq: register-map vector table plus
// hand-written sequences for overflow, blocking, collisions and reset.
module tb_tick_irq;
  localparam logic [15:0] B = 16'h2000;

  logic clk;
  logic resetq;
  logic fetch_pending;
  logic interrupt;

  tick_irq_if bus ();

  tick_irq #(.BASE(B)) dut (
    .clk           (clk),
    .resetq        (resetq),
    .io            (bus.slave),
    .fetch_pending (fetch_pending),
    .interrupt     (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [15:0] raddr;
    logic [15:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  vec_t vecs [12];
  sb_t  sb [$];
  int   chk_cnt;
  int   pass_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 16'h%04h, want 16'h%04h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    bus.io_addr = addr;
    bus.io_dout = data;
    bus.io_wr   = 1'b1;
    tick();
    bus.io_wr   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
    sb_t e;
    bus.io_addr = addr;
    bus.io_rd   = 1'b1;
    sb.push_back('{name, exp});
    #1;
    e = sb.pop_front();
    chk(e.name, bus.io_din, e.exp);
    bus.io_rd   = 1'b0;
  endtask

  task automatic chk_irq(input logic exp, input string name);
    #1;
    chk(name, {15'd0, interrupt}, {15'd0, exp});
  endtask

  initial begin
    int pulses;
    chk_cnt  = 0;
    pass_cnt = 0;
    resetq        = 1'b0;
    fetch_pending = 1'b0;
    bus.io_wr     = 1'b0;
    bus.io_rd     = 1'b0;
    bus.io_addr   = 16'd0;
    bus.io_dout   = 16'd0;

    vecs[0]  = '{1'b0, 16'h0000, 16'h0000, B,          16'h0000, "rst_ticks"};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0000, B + 16'd1,  16'h0000, "rst_reload"};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, B + 16'd2,  16'h0000, "rst_ctrl"};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, B + 16'd3,  16'h0000, "rst_lost"};
    vecs[4]  = '{1'b0, 16'h0000, 16'h0000, B + 16'd4,  16'h0000, "unmapped_rd"};
    vecs[5]  = '{1'b1, B + 16'd1, 16'hA5A5, B + 16'd1, 16'hA5A5, "reload_rw"};
    vecs[6]  = '{1'b1, B,         16'h1234, B,         16'h1234, "ticks_rw"};
    vecs[7]  = '{1'b1, B + 16'd2, 16'hFFF8, B + 16'd2, 16'h0000, "ctrl_upper_ignored"};
    vecs[8]  = '{1'b1, B + 16'd5, 16'h5555, B,         16'h1234, "unmapped_wr"};
    vecs[9]  = '{1'b1, 16'h1FFF,  16'hFFFF, B + 16'd1, 16'hA5A5, "below_base_wr"};
    vecs[10] = '{1'b1, B + 16'd3, 16'hFFFF, B + 16'd3, 16'h0000, "lost_wr"};
    vecs[11] = '{1'b1, B + 16'd1, 16'h0000, B + 16'd1, 16'h0000, "reload_clear"};

    repeat (3) @(posedge clk);
    #3 resetq = 1'b1;
    tick();
    chk_irq(1'b0, "rst_irq");

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, vecs[i].exp, vecs[i].name);
    end

    // Reload and overflow, single-cycle delivery.
    wr(B + 16'd1, 16'hFFF0);
    wr(B,         16'hFFFE);
    wr(B + 16'd2, 16'h0003);
    rd(B, 16'hFFFE, "ovf_t0");
    tick();
    rd(B, 16'hFFFF, "ovf_t1");
    chk_irq(1'b0, "ovf_irq_t1");
    tick();
    rd(B,         16'hFFF0, "ovf_reload");
    rd(B + 16'd2, 16'h0007, "ovf_pend_set");
    chk_irq(1'b0, "ovf_irq_t2");
    tick();
    chk_irq(1'b1, "ovf_irq_pulse");
    tick();
    chk_irq(1'b0, "ovf_irq_one_cycle");
    rd(B + 16'd2, 16'h0001, "ovf_ctrl_after");
    wr(B + 16'd2, 16'h0004);

    // Fetch blocking.
    fetch_pending = 1'b1;
    wr(B + 16'd1, 16'h0000);
    wr(B,         16'hFFFF);
    wr(B + 16'd2, 16'h0003);
    wr(B + 16'd2, 16'h0002);
    rd(B + 16'd2, 16'h0006, "blk_ctrl");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_irq(1'b0, "blk_held");
    end
    fetch_pending = 1'b0;
    chk_irq(1'b1, "blk_release");
    tick();
    chk_irq(1'b0, "blk_after");
    rd(B + 16'd2, 16'h0000, "blk_ctrl_cleared");

    // Lost-event saturation, then software re-enable.
    wr(B + 16'd1, 16'hFFFE);
    wr(B,         16'hFFFE);
    wr(B + 16'd3, 16'h0000);
    wr(B + 16'd2, 16'h0001);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i % 8 == 0) chk_irq(1'b0, "lost_no_irq");
    end
    wr(B + 16'd2, 16'h0000);
    rd(B + 16'd2, 16'h0004, "lost_pend");
    rd(B + 16'd3, 16'h000F, "lost_saturated");
    wr(B + 16'd2, 16'h0002);
    chk_irq(1'b0, "reen_idle");
    tick();
    chk_irq(1'b1, "reen_pulse");
    tick();
    chk_irq(1'b0, "reen_after");
    wr(B + 16'd3, 16'h0000);
    rd(B + 16'd3, 16'h0000, "lost_cleared");

    // TICKS write collides with overflow.
    wr(B,         16'hFFFF);
    wr(B + 16'd2, 16'h0001);
    wr(B,         16'h1234);
    rd(B,         16'h1234, "wcol_ticks");
    rd(B + 16'd2, 16'h0001, "wcol_pend_zero");
    wr(B + 16'd2, 16'h0000);

    // PEND clear collides with overflow.
    wr(B + 16'd3, 16'h0000);
    wr(B + 16'd1, 16'hFFFE);
    wr(B,         16'hFFFF);
    wr(B + 16'd2, 16'h0001);
    tick();
    rd(B + 16'd2, 16'h0005, "ccol_pend_first");
    rd(B + 16'd3, 16'h0000, "ccol_lost_first");
    tick();
    wr(B + 16'd2, 16'h0004);
    rd(B + 16'd2, 16'h0004, "ccol_pend_kept");
    rd(B + 16'd3, 16'h0001, "ccol_lost_inc");
    rd(B,         16'hFFFE, "ccol_ticks");

    // Reset while a request is held off by a fetch.
    fetch_pending = 1'b1;
    wr(B + 16'd2, 16'h0002);
    tick();
    chk_irq(1'b0, "rreq_blocked");
    rd(B + 16'd2, 16'h0006, "rreq_ctrl");
    #1 resetq = 1'b0;
    chk_irq(1'b0, "rreq_irq_in_reset");
    rd(B + 16'd1, 16'h0000, "rreq_reload_in_reset");
    tick();
    #2 resetq = 1'b1;
    fetch_pending = 1'b0;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (interrupt) pulses++;
    end
    chk("rreq_no_pulse", pulses[15:0], 16'd0);
    rd(B,         16'h0000, "rreq_ticks");
    rd(B + 16'd1, 16'h0000, "rreq_reload");
    rd(B + 16'd2, 16'h0000, "rreq_ctrl_zero");
    rd(B + 16'd3, 16'h0000, "rreq_lost");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
